number_entry: RTL and testbench

NUMBER_ENTRY -- requirements
Module: number_entry

---
 rtl/number_entry.sv | 138 +++++++++++++
 tb/tb_number_entry.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/number_entry.sv
// Keypad number entry: collects up to MAX_DIGITS decimal digits per number,
// supports backspace, and commits up to four numbers into output slots that
// feed number_converter. Every output comes straight from a register.
module number_entry #(
  parameter int MAX_DIGITS = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       digit_stb,
  input  logic [3:0] digit,
  input  logic       bksp_stb,
  input  logic       enter_stb,
  input  logic       clr_all,
  output logic [9:0] num1,
  output logic [9:0] num2,
  output logic [9:0] num3,
  output logic [9:0] num4,
  output logic [3:0] valid,
  output logic [1:0] slot,
  output logic [9:0] cur_val,
  output logic [1:0] cur_cnt,
  output logic       full
);

  localparam int         DW      = 4 * MAX_DIGITS;
  localparam logic [1:0] MAX_CNT = 2'(MAX_DIGITS);

  typedef enum logic {ST_ENTRY, ST_FULL} state_t;

  state_t        state_reg;
  logic [DW-1:0] d_reg;        // nibble k holds the digit of weight 10^k
  logic [1:0]    cnt_reg;
  logic [9:0]    val_reg;
  logic [1:0]    slot_reg;
  logic [3:0]    valid_reg;
  logic          full_reg;
  logic [9:0]    num_reg [4];

  logic [DW-1:0] d_ins_next;   // digit register after shifting a new digit in
  logic [DW-1:0] d_del_next;   // digit register after a backspace
  logic [9:0]    ins_val_next;
  logic [9:0]    del_val_next;
  logic          digit_ok;

  // Build the shifted digit vectors nibble by nibble so any MAX_DIGITS works
  generate
    for (genvar gi = 0; gi < MAX_DIGITS; gi++) begin : g_shift
      if (gi == 0) begin : g_ins_low
        assign d_ins_next[3:0] = digit;
      end else begin : g_ins_up
        assign d_ins_next[4*gi +: 4] = d_reg[4*(gi-1) +: 4];
      end
      if (gi == MAX_DIGITS - 1) begin : g_del_top
        assign d_del_next[4*gi +: 4] = 4'd0;
      end else begin : g_del_low
        assign d_del_next[4*gi +: 4] = d_reg[4*(gi+1) +: 4];
      end
    end
  endgenerate

  // Horner evaluation of the decimal digits, most significant first
  function automatic logic [9:0] to_val(input logic [DW-1:0] dv);
    logic [13:0] acc;
    acc = '0;
    for (int k = MAX_DIGITS - 1; k >= 0; k--) begin
      acc = acc * 14'd10 + {10'd0, dv[4*k +: 4]};
    end
    return acc[9:0];
  endfunction

  assign ins_val_next = to_val(d_ins_next);
  assign del_val_next = to_val(d_del_next);
  assign digit_ok     = (cnt_reg < MAX_CNT) && (digit <= 4'd9);

  // Entry/full state machine; clr_all and rst share the same clearing path,
  // and within ENTRY only the highest-priority asserted strobe is considered
  always_ff @(posedge clk) begin
    if (rst || clr_all) begin
      state_reg <= ST_ENTRY;
      d_reg     <= '0;
      cnt_reg   <= '0;
      val_reg   <= '0;
      slot_reg  <= '0;
      valid_reg <= '0;
      full_reg  <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        num_reg[i] <= '0;
      end
    end else begin
      case (state_reg)
        ST_ENTRY: begin
          if (enter_stb) begin
            if (cnt_reg != 2'd0) begin
              num_reg[slot_reg]   <= val_reg;
              valid_reg[slot_reg] <= 1'b1;
              d_reg               <= '0;
              cnt_reg             <= '0;
              val_reg             <= '0;
              if (slot_reg == 2'd3) begin
                full_reg  <= 1'b1;
                state_reg <= ST_FULL;
              end else begin
                slot_reg <= slot_reg + 2'd1;
              end
            end
          end else if (bksp_stb) begin
            if (cnt_reg != 2'd0) begin
              d_reg   <= d_del_next;
              val_reg <= del_val_next;
              cnt_reg <= cnt_reg - 2'd1;
            end
          end else if (digit_stb) begin
            if (digit_ok) begin
              d_reg   <= d_ins_next;
              val_reg <= ins_val_next;
              cnt_reg <= cnt_reg + 2'd1;
            end
          end
        end
        ST_FULL: begin
          // Everything holds until clr_all or rst
        end
        default: state_reg <= ST_ENTRY;
      endcase
    end
  end

  assign num1    = num_reg[0];
  assign num2    = num_reg[1];
  assign num3    = num_reg[2];
  assign num4    = num_reg[3];
  assign valid   = valid_reg;
  assign slot    = slot_reg;
  assign cur_val = val_reg;
  assign cur_cnt = cnt_reg;
  assign full    = full_reg;

endmodule

// File: tb/tb_number_entry.sv
// Self-checking bench for number_entry: an arithmetic model of the entry
// (value*10+digit, value/10) compared against the DUT every cycle, plus
// directed scenarios with literal expectations and a randomized phase.
module tb_number_entry;

  localparam int MAXD = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       digit_stb = 1'b0;
  logic [3:0] digit = 4'd0;
  logic       bksp_stb = 1'b0;
  logic       enter_stb = 1'b0;
  logic       clr_all = 1'b0;
  logic [9:0] num1, num2, num3, num4;
  logic [3:0] valid;
  logic [1:0] slot;
  logic [9:0] cur_val;
  logic [1:0] cur_cnt;
  logic       full;

  int n_pass  = 0;
  int n_total = 0;
  bit chk_en  = 1'b0;

  number_entry #(.MAX_DIGITS(MAXD)) dut (
    .clk(clk), .rst(rst), .digit_stb(digit_stb), .digit(digit),
    .bksp_stb(bksp_stb), .enter_stb(enter_stb), .clr_all(clr_all),
    .num1(num1), .num2(num2), .num3(num3), .num4(num4),
    .valid(valid), .slot(slot), .cur_val(cur_val), .cur_cnt(cur_cnt),
    .full(full)
  );

  always #5 clk = ~clk;

  // Reference model: plain integers, the entry kept as a number not digits
  int         m_val = 0;
  int         m_cnt = 0;
  int         m_slot = 0;
  logic [3:0] m_valid = 4'd0;
  logic       m_full = 1'b0;
  int         m_num [4] = '{0, 0, 0, 0};

  always @(posedge clk) begin
    if (rst || clr_all) begin
      m_val <= 0; m_cnt <= 0; m_slot <= 0; m_valid <= 4'd0; m_full <= 1'b0;
      for (int i = 0; i < 4; i++) m_num[i] <= 0;
    end else if (!m_full) begin
      if (enter_stb) begin
        if (m_cnt > 0) begin
          m_num[m_slot]   <= m_val;
          m_valid[m_slot] <= 1'b1;
          m_val <= 0;
          m_cnt <= 0;
          if (m_slot == 3) m_full <= 1'b1;
          else m_slot <= m_slot + 1;
        end
      end else if (bksp_stb) begin
        if (m_cnt > 0) begin
          m_val <= m_val / 10;
          m_cnt <= m_cnt - 1;
        end
      end else if (digit_stb) begin
        if (m_cnt < MAXD && int'(digit) <= 9) begin
          m_val <= m_val * 10 + int'(digit);
          m_cnt <= m_cnt + 1;
        end
      end
    end
  end

  // Per-cycle comparison of every output against the model
  logic [58:0] act_vec, exp_vec;
  always @(negedge clk) begin
    if (chk_en) begin
      act_vec = {num1, num2, num3, num4, valid, slot, cur_val, cur_cnt, full};
      exp_vec = {10'(m_num[0]), 10'(m_num[1]), 10'(m_num[2]), 10'(m_num[3]),
                 m_valid, 2'(m_slot), 10'(m_val), 2'(m_cnt), m_full};
      n_total++;
      if (act_vec === exp_vec) n_pass++;
      else $display("FAIL model_cycle t=%0t: got %h expected %h", $time, act_vec, exp_vec);
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // One clock of stimulus; returns at the following negedge
  task automatic cyc(input logic r, input logic cl, input logic en,
                     input logic bk, input logic ds, input logic [3:0] dg);
    rst = r; clr_all = cl; enter_stb = en; bksp_stb = bk; digit_stb = ds; digit = dg;
    @(negedge clk);
    rst = 1'b0; clr_all = 1'b0; enter_stb = 1'b0; bksp_stb = 1'b0; digit_stb = 1'b0;
  endtask

  task automatic dig(input int v);  cyc(0, 0, 0, 0, 1, 4'(v)); endtask
  task automatic ent();             cyc(0, 0, 1, 0, 0, 4'd0);  endtask
  task automatic bks();             cyc(0, 0, 0, 1, 0, 4'd0);  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_nums"}, int'(num1) + int'(num2) + int'(num3) + int'(num4), 0);
    chk({tag, "_valid"}, int'(valid), 0);
    chk({tag, "_slot"}, int'(slot), 0);
    chk({tag, "_curval"}, int'(cur_val), 0);
    chk({tag, "_curcnt"}, int'(cur_cnt), 0);
    chk({tag, "_full"}, int'(full), 0);
  endtask

  initial begin
    @(negedge clk);
    cyc(1, 0, 0, 0, 0, 4'd0);
    chk_en = 1'b1;
    chk_all_zero("reset");

    // 1,2,3 enter
    dig(1); chk("lat_first_digit", int'(cur_val), 1);
    dig(2); dig(3);
    chk("val_123", int'(cur_val), 123);
    ent();
    chk("num1_123", int'(num1), 123);
    chk("valid_0001", int'(valid), 1);
    chk("slot_1", int'(slot), 1);
    chk("cnt_after_commit", int'(cur_cnt), 0);

    // 4,5,6,7 with the 7 dropped, then backspace
    dig(4); dig(5); dig(6); dig(7);
    chk("val_456", int'(cur_val), 456);
    chk("cnt_full_entry", int'(cur_cnt), 3);
    bks();
    chk("bksp_val_45", int'(cur_val), 45);
    chk("bksp_cnt_2", int'(cur_cnt), 2);
    dig(6); ent();
    chk("num2_456", int'(num2), 456);
    dig(1); dig(8); dig(9); ent();
    dig(12); chk("illegal_digit_ignored", int'(cur_cnt), 0);
    dig(1); dig(4); ent();
    chk("num3_189", int'(num3), 189);
    chk("num4_14", int'(num4), 14);
    chk("valid_1111", int'(valid), 15);
    chk("full_set", int'(full), 1);
    chk("slot_stays_3", int'(slot), 3);
    dig(9);
    chk("full_digit_cnt", int'(cur_cnt), 0);
    chk("full_hold_num1", int'(num1), 123);
    chk("full_hold", int'(full), 1);

    // empty enter and explicit zero
    cyc(0, 1, 0, 0, 0, 4'd0);
    chk_all_zero("clr");
    ent();
    chk("empty_enter_slot", int'(slot), 0);
    chk("empty_enter_valid", int'(valid), 0);
    dig(0);
    chk("zero_cnt", int'(cur_cnt), 1);
    ent();
    chk("zero_committed_valid", int'(valid), 1);
    chk("zero_committed_num1", int'(num1), 0);

    // enter beats digit; clr beats enter
    dig(1); dig(2);
    cyc(0, 0, 1, 0, 1, 4'd5);
    chk("enter_wins_num2", int'(num2), 12);
    chk("enter_wins_cnt", int'(cur_cnt), 0);
    chk("enter_wins_slot", int'(slot), 2);
    dig(3);
    cyc(0, 1, 1, 0, 0, 4'd0);
    chk_all_zero("clr_wins");

    // rst mid-entry after two commits
    dig(7); ent(); dig(8); ent(); dig(4); dig(2);
    chk("pre_rst_cnt", int'(cur_cnt), 2);
    cyc(1, 0, 0, 0, 0, 4'd0);
    chk_all_zero("rst_mid");
    dig(5); ent();
    chk("resume_num1", int'(num1), 5);
    chk("resume_slot", int'(slot), 1);

    // randomized phase, checked by the per-cycle model compare
    for (int i = 0; i < 4000; i++) begin
      cyc(($urandom_range(0, 199) == 0), ($urandom_range(0, 79) == 0),
          ($urandom_range(0, 5) == 0), ($urandom_range(0, 7) == 0),
          ($urandom_range(0, 1) == 0), 4'($urandom_range(0, 15)));
    end

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
